// File: rtl/alu_seq_pkg.sv
// Shared types for the constant-operand ALU sequencer: operation and constant
// encodings, the controller states and the packed per-step program word.
package alu_seq_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_e;
  typedef enum logic [1:0] {C1, C3, C5, C7} csel_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    op_e   op;
    csel_e csel;
  } step_t;

endpackage

// File: rtl/alu_sequencer.sv
// Initiator for the external constant-operand ALU: runs a latched program of up
// to N_STEPS steps, feeding each result back, and returns the final value.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N_STEPS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DATA_W-1:0]    cmd_seed,
  input  logic [4*N_STEPS-1:0] cmd_program,
  input  logic [2:0]           cmd_len,
  input  logic                 cmd_stop_on_zero,
  output logic [DATA_W-1:0]    alu_input,
  output logic [1:0]           alu_const_sel,
  output logic [1:0]           alu_op,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_status,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_value,
  output logic [3:0]           res_steps,
  output logic                 res_zero_stop
);

  state_e                 state_reg, state_next;
  logic [4*N_STEPS-1:0]   prog_reg;
  logic [2:0]             len_reg;
  logic                   stop_reg;
  logic [DATA_W-1:0]      acc_reg;
  logic [2:0]             idx_reg;
  logic [DATA_W-1:0]      res_value_reg;
  logic [3:0]             res_steps_reg;
  logic                   res_zero_stop_reg;

  step_t                  steps [N_STEPS];
  step_t                  cur_step;
  logic                   early_stop;
  logic                   finish;

  for (genvar gi = 0; gi < N_STEPS; gi++) begin : g_steps
    assign steps[gi] = step_t'(prog_reg[4*gi +: 4]);
  end

  assign cur_step   = steps[idx_reg];
  // A zero on the final step is a normal finish, never an early stop.
  assign early_stop = stop_reg & alu_status & (idx_reg < len_reg);
  assign finish     = (idx_reg == len_reg) | early_stop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = RUN;
      RUN:     if (finish)    state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prog_reg          <= '0;
      len_reg           <= '0;
      stop_reg          <= 1'b0;
      acc_reg           <= '0;
      idx_reg           <= '0;
      res_value_reg     <= '0;
      res_steps_reg     <= '0;
      res_zero_stop_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            prog_reg <= cmd_program;
            len_reg  <= cmd_len;
            stop_reg <= cmd_stop_on_zero;
            acc_reg  <= cmd_seed;
            idx_reg  <= '0;
          end
        end
        RUN: begin
          if (finish) begin
            res_value_reg     <= alu_result;
            res_steps_reg     <= {1'b0, idx_reg} + 4'd1;
            res_zero_stop_reg <= early_stop;
          end else begin
            acc_reg <= alu_result;
            idx_reg <= idx_reg + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready     = (state_reg == IDLE);
    res_valid     = (state_reg == DONE);
    alu_input     = acc_reg;
    alu_op        = OP_ADD;
    alu_const_sel = C1;
    if (state_reg == RUN) begin
      alu_op        = cur_step.op;
      alu_const_sel = cur_step.csel;
    end
  end

  assign res_value     = res_value_reg;
  assign res_steps     = res_steps_reg;
  assign res_zero_stop = res_zero_stop_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized bench for alu_sequencer with a behavioural ALU
// beside it and a plain-arithmetic reference model of whole programs.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_seed;
  logic [31:0] cmd_program;
  logic [2:0]  cmd_len;
  logic        cmd_stop_on_zero;
  logic [7:0]  alu_input;
  logic [1:0]  alu_const_sel;
  logic [1:0]  alu_op;
  logic [7:0]  alu_result;
  logic        alu_status;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_value;
  logic [3:0]  res_steps;
  logic        res_zero_stop;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_in [8];
  logic [1:0] m_op [8];
  logic [1:0] m_cs [8];
  logic [7:0] m_value;
  int         m_steps;
  logic       m_zs;
  logic [7:0] last_value;
  logic [3:0] last_steps;
  logic       last_zs;

  always #5 clk = ~clk;

  alu_sequencer #(.N_STEPS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seed(cmd_seed),
    .cmd_program(cmd_program), .cmd_len(cmd_len), .cmd_stop_on_zero(cmd_stop_on_zero),
    .alu_input(alu_input), .alu_const_sel(alu_const_sel), .alu_op(alu_op),
    .alu_result(alu_result), .alu_status(alu_status),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
    .res_steps(res_steps), .res_zero_stop(res_zero_stop)
  );

  function automatic logic [7:0] alu_calc(input logic [7:0] a, input logic [1:0] op,
                                          input logic [1:0] cs);
    int k;
    int r;
    k = 2 * int'(cs) + 1;
    case (op)
      2'd0:    r = (int'(a) + k) % 256;
      2'd1:    r = (int'(a) - k + 256) % 256;
      2'd2:    r = int'(a) & k;
      default: r = int'(a) | k;
    endcase
    return 8'(r);
  endfunction

  // External ALU stand-in
  assign alu_result = alu_calc(alu_input, alu_op, alu_const_sel);
  assign alu_status = (alu_result == 8'd0);

  function automatic void model(input logic [7:0] seed, input logic [31:0] prog,
                                input int len, input logic stop);
    logic [7:0] acc;
    logic [7:0] r;
    acc = seed;
    for (int k = 0; k <= len; k++) begin
      m_in[k] = acc;
      m_op[k] = prog[4*k+2 +: 2];
      m_cs[k] = prog[4*k +: 2];
      r = alu_calc(acc, m_op[k], m_cs[k]);
      if (k == len) begin
        m_value = r; m_steps = k + 1; m_zs = 1'b0;
        break;
      end else if (stop && r == 8'd0) begin
        m_value = r; m_steps = k + 1; m_zs = 1'b1;
        break;
      end
      acc = r;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scribble_cmd();
    cmd_seed         = 8'($urandom);
    cmd_program      = $urandom;
    cmd_len          = 3'($urandom);
    cmd_stop_on_zero = 1'($urandom);
  endtask

  task automatic run_cmd(input logic [7:0] seed, input logic [31:0] prog,
                         input logic [2:0] len, input logic stop, input int hold);
    model(seed, prog, int'(len), stop);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_seed = seed; cmd_program = prog;
    cmd_len = len; cmd_stop_on_zero = stop;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < m_steps; c++) begin
      @(negedge clk);
      chk("run_res_valid", 32'(res_valid), 0);
      chk("run_cmd_ready", 32'(cmd_ready), 0);
      chk($sformatf("alu_input_step%0d", c), 32'(alu_input), 32'(m_in[c]));
      chk($sformatf("alu_op_step%0d", c), 32'(alu_op), 32'(m_op[c]));
      chk($sformatf("alu_csel_step%0d", c), 32'(alu_const_sel), 32'(m_cs[c]));
      cmd_valid = 1'($urandom);
      scribble_cmd();
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("done_res_valid", 32'(res_valid), 1);
    chk("done_res_value", 32'(res_value), 32'(m_value));
    chk("done_res_steps", 32'(res_steps), 32'(m_steps));
    chk("done_zero_stop", 32'(res_zero_stop), 32'(m_zs));
    chk("done_cmd_ready", 32'(cmd_ready), 0);
    chk("done_alu_op", 32'(alu_op), 0);
    chk("done_alu_csel", 32'(alu_const_sel), 0);
    last_value = res_value; last_steps = res_steps; last_zs = res_zero_stop;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      scribble_cmd();
      @(negedge clk);
      chk("hold_res_valid", 32'(res_valid), 1);
      chk("hold_res_value", 32'(res_value), 32'(m_value));
      chk("hold_res_steps", 32'(res_steps), 32'(m_steps));
      chk("hold_cmd_ready", 32'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("post_hs_res_valid", 32'(res_valid), 0);
    chk("post_hs_cmd_ready", 32'(cmd_ready), 1);
    $display("cmd seed=%02h prog=%08h len=%0d stop=%0d -> value=%02h steps=%0d zstop=%0d",
             seed, prog, len, stop, last_value, last_steps, last_zs);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_value"}, 32'(res_value), 0);
    chk({tag, "_res_steps"}, 32'(res_steps), 0);
    chk({tag, "_res_zstop"}, 32'(res_zero_stop), 0);
    chk({tag, "_alu_input"}, 32'(alu_input), 0);
    chk({tag, "_alu_op"}, 32'(alu_op), 0);
    chk({tag, "_alu_csel"}, 32'(alu_const_sel), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; res_ready = 1'b0;
    cmd_valid = 1'b1;
    scribble_cmd();
    repeat (2) @(negedge clk);
    chk_reset_outputs("in_reset");
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("after_reset_cmd_ready", 32'(cmd_ready), 1);
    chk("after_reset_res_valid", 32'(res_valid), 0);

    run_cmd(8'h10, 32'h0000_0003, 3'd0, 1'b0, 0);
    chk("single_add_value", 32'(last_value), 32'h17);
    chk("single_add_steps", 32'(last_steps), 1);
    run_cmd(8'hFE, 32'h0000_0001, 3'd0, 1'b0, 0);
    chk("wrap_add_value", 32'(last_value), 32'h01);
    run_cmd(8'h00, 32'h0000_0004, 3'd0, 1'b0, 0);
    chk("wrap_sub_value", 32'(last_value), 32'hFF);
    run_cmd(8'h00, 32'hCB02_49E3, 3'd7, 1'b0, 0);
    chk("chain_value", 32'(last_value), 32'h01);
    chk("chain_steps", 32'(last_steps), 8);
    run_cmd(8'h05, 32'h0000_0006, 3'd1, 1'b1, 0);
    chk("early_value", 32'(last_value), 32'h00);
    chk("early_steps", 32'(last_steps), 1);
    chk("early_zstop", 32'(last_zs), 1);
    run_cmd(8'h05, 32'h0000_0006, 3'd1, 1'b0, 0);
    chk("nostop_value", 32'(last_value), 32'h01);
    chk("nostop_steps", 32'(last_steps), 2);
    chk("nostop_zstop", 32'(last_zs), 0);
    run_cmd(8'h05, 32'h0000_0006, 3'd0, 1'b1, 0);
    chk("last_zero_value", 32'(last_value), 32'h00);
    chk("last_zero_zstop", 32'(last_zs), 0);
    run_cmd(8'h10, 32'h0000_0003, 3'd0, 1'b0, 5);
    chk("backpressure_value", 32'(last_value), 32'h17);

    // Reset asserted between clock edges during step 2 of an 8-step program
    @(negedge clk);
    cmd_valid = 1'b1; cmd_seed = 8'h00; cmd_program = 32'hCB02_49E3;
    cmd_len = 3'd7; cmd_stop_on_zero = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_reset_alu_input", 32'(alu_input), 32'h07);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_reset_no_result", 32'(res_valid), 0);
    end
    $display("reset mid-run: pending result discarded");
    run_cmd(8'h00, 32'hCB02_49E3, 3'd7, 1'b0, 1);
    chk("post_reset_chain_value", 32'(last_value), 32'h01);

    for (int t = 0; t < 25; t++) begin
      logic [7:0]  s;
      logic [31:0] p;
      logic [2:0]  l;
      logic        z;
      s = 8'($urandom);
      p = $urandom;
      l = 3'($urandom);
      z = 1'($urandom);
      if (t % 3 == 0) s = 8'($urandom_range(0, 7));
      run_cmd(s, p, l, z, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Initiator side of the 8-bit constant-operand ALU interface. It accepts a command containing a seed value and a short program of up to 8 (operation, constant) steps.
- It drives the ALU one step per cycle and feeds each result back as the next input.
- It can stop early when the ALU reports a zero result, then returns the final value through a valid/ready result port.
- The ALU itself is instantiated beside this block at the top level.

## Interface
- `N_STEPS`, default 8. Maximum program length; `cmd_program` width is 4*`N_STEPS`.
- `clk` in 1. Single clock, rising edge.
- `reset_n` in 1. Asynchronous, active-low reset.
- `cmd_valid` in 1. Command offered.
- `cmd_ready` out 1. High only in IDLE.
- `cmd_seed` in 8. Initial ALU input.
- `cmd_program` in 4*`N_STEPS`. Step k is bits [4k+3:4k]; [4k+3:4k+2]=op, [4k+1:4k]=const_sel.
- `cmd_len` in 3. Number of steps minus 1 (0 means 1 step).
- `cmd_stop_on_zero` in 1. Terminate early when `alu_status`=1.
- `alu_input` out 8. Operand to the ALU.
- `alu_const_sel` out 2. Constant select: 0→1, 1→3, 2→5, 3→7.
- `alu_op` out 2. Operation: 0 ADD, 1 SUB, 2 AND, 3 OR.
- `alu_result` in 8. Combinational ALU result, mod 256.
- `alu_status` in 1. ALU zero flag (`alu_result`==0).
- `res_valid` out 1. Result available; held until accepted.
- `res_ready` in 1. Consumer accepts the result.
- `res_value` out 8. Final ALU result.
- `res_steps` out 4. Steps executed, 1..8.
- `res_zero_stop` out 1. 1 if terminated early by zero before step `cmd_len`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:** `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`: latch program, len and stop flag; acc←`cmd_seed`; idx←0; go to RUN.
- **RUN:** drive `alu_input`=acc, and `alu_op`/`alu_const_sel` from step idx. At each clock edge:
  - If idx==len, or (stop_on_zero & `alu_status` & idx<len): `res_value`←`alu_result`, `res_steps`←idx+1, `res_zero_stop`←(early stop), go to DONE.
  - Otherwise: acc←`alu_result`, idx←idx+1.
- **DONE:** `res_valid`=1. Result fields stay stable while `res_ready`=0. On `res_ready`, return to IDLE and `res_valid` falls.
- **Outside RUN:** `alu_op`=0, `alu_const_sel`=0, `alu_input`=acc.
- **Arithmetic:** all wrap-around is done by the ALU (mod 256). This block never alters `alu_result`.
- **Command latching:** `cmd_*` inputs are sampled only at acceptance. Later changes to them have no effect.
- **Stop-on-zero at the last step:** a zero on step idx==len is a normal finish, so `res_zero_stop`=0.
- **`cmd_valid` outside IDLE:** ignored. There is no queueing.

## Timing
- **Reset values:**
  - State IDLE, `cmd_ready`=1, acc=0, idx=0.
  - `res_valid`=0, `res_value`=0, `res_steps`=0, `res_zero_stop`=0.
  - `alu_op`=0, `alu_const_sel`=0, `alu_input`=0.
  - No command is accepted while `reset_n`=0.
- **Latency:** if the command is accepted at edge E0, `res_valid` rises after edge E0+(len+1) for a full run. An early stop at step k gives E0+(k+1).
- **Throughput:**
  - `cmd_ready` falls the cycle after acceptance and returns the cycle after the result handshake.
  - Minimum command-to-command spacing is len+3 cycles.
- **Reset mid-operation:** asserting `reset_n` low in RUN or DONE immediately forces all reset values. A pending result is lost.

## Structure
- **Package `alu_seq_pkg`:**
  - `op_e` (`OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`).
  - `csel_e` (`C1`, `C3`, `C5`, `C7`).
  - `state_e` (IDLE, RUN, DONE).
  - Packed `step_t` {op, csel}.
  - Constant `DATA_W`=8.
- **Sub-modules:** none required. The ALU stays external so that the same ALU can be driven by other initiators.

## Test plan
- **Single ADD:** seed 0x10, step0 = ADD/C7, len 0 → one RUN cycle; `res_value`=0x17, `res_steps`=1, `res_zero_stop`=0.
- **Wrap-around:** seed 0xFE, step0 = ADD/C3 → 0x01. Seed 0x00, step0 = SUB/C1 → 0xFF.
- **Full 8-step chain:** seed 0x00, steps = ADD/C7, OR/C5, AND/C3, SUB/C1, ADD/C5, ADD/C1, AND/C7, OR/C1, len 7.
  - Per-step `alu_input` sequence: 00, 07, 07, 03, 02, 07, 08, 00.
  - Result 0x01, `res_steps`=8, `res_valid` 8 cycles after acceptance.
- **Early stop:** seed 0x05, step0 = SUB/C5, step1 = ADD/C1, len 1.
  - With `cmd_stop_on_zero`=1: `res_value`=0x00, `res_steps`=1, `res_zero_stop`=1.
  - With `cmd_stop_on_zero`=0: `res_value`=0x01, `res_steps`=2, `res_zero_stop`=0.
- **Backpressure:** hold `res_ready`=0 for 5 cycles.
  - `res_valid`/`res_value` stay stable and `cmd_ready`=0.
  - A `cmd_valid` pulse during this time is ignored.
  - When `res_ready`=1, the handshake occurs and `cmd_ready`=1 the next cycle.
- **Reset mid-run:** pulse `reset_n` low during step 2 of a len-7 program.
  - All outputs return to reset values asynchronously and no result is emitted.
  - A new command then runs correctly.
